// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver shared types and frame constants
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - received-byte bus from the PS/2 receiver to its consumers
interface ps2_rx_if;

    logic [7:0] BYTE_OUT;
    logic       BYTE_VALID_OUT;
    logic       PARITY_ERR_OUT;
    logic       FRAME_ERR_OUT;
    logic       BUSY_OUT;

    modport master (
        output BYTE_OUT, BYTE_VALID_OUT, PARITY_ERR_OUT, FRAME_ERR_OUT, BUSY_OUT
    );

    modport slave (
        input BYTE_OUT, BYTE_VALID_OUT, PARITY_ERR_OUT, FRAME_ERR_OUT, BUSY_OUT
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 clock synchronizer, glitch filter and falling-edge strobe
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK100_IN,
    input  logic rst_n,
    input  logic ps2_clk_i,
    output logic fall_stb_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fall_d = 1'b0;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ps2_clk_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fall_stb_o = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 serial frame receiver producing parallel bytes with status strobes
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic      CLK100_IN,
    input  logic      rst_n,
    input  logic      PS2_CLK_IN,
    input  logic      PS2_DATA_IN,
    ps2_rx_if.master  bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          fall_stb;
    logic          dsync1_q, dsync2_q;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .CLK100_IN  (CLK100_IN),
        .rst_n      (rst_n),
        .ps2_clk_i  (PS2_CLK_IN),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tmo_d     = (state_q == IDLE || fall_stb) ? '0 : tmo_q + TW'(1);

        if (fall_stb) begin
            case (state_q)
                IDLE: begin
                    if (dsync2_q == START_BIT) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dsync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = (^shift_q) ^ dsync2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    // A bad stop bit masks any parity verdict for the same frame.
                    if (dsync2_q != STOP_BIT) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok_q) begin
                        perr_d = 1'b1;
                    end else begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            dsync1_q  <= 1'b1;
            dsync2_q  <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            dsync1_q  <= PS2_DATA_IN;
            dsync2_q  <= dsync1_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.BYTE_OUT       = byte_q;
    assign bus.BYTE_VALID_OUT = valid_q;
    assign bus.PARITY_ERR_OUT = perr_q;
    assign bus.FRAME_ERR_OUT  = ferr_q;
    assign bus.BUSY_OUT       = (state_q != IDLE);

endmodule
